instruction_fetch_unit: RTL and testbench

//  Fetch stage directly upstream of the program-memory ROM: owns the program counter (PC) and drives the ROM byte address.

---
 rtl/instruction_fetch_unit.sv | 107 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: owns the PC, addresses the asynchronous program ROM and fills the IF/ID register.
// Optional build macro FETCH_ALIGN_CHECK_EN traps misaligned redirects to TRAP_VECTOR and pulses AlignError.
module instruction_fetch_unit #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0040,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD     = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic                  BranchTaken,
  input  logic [DATA_WIDTH-1:0] BranchTarget,
  input  logic                  Jump,
  input  logic [DATA_WIDTH-1:0] JumpTarget,
  output logic [DATA_WIDTH-1:0] PCAddress,
  input  logic [DATA_WIDTH-1:0] Instruction,
  output logic [DATA_WIDTH-1:0] InstructionID,
  output logic [DATA_WIDTH-1:0] PCPlus4ID,
  output logic                  ValidID,
  output logic                  AlignError
);

  typedef enum logic [1:0] {
    SRC_SEQ,
    SRC_HOLD,
    SRC_REDIRECT,
    SRC_TRAP
  } pc_src_e;

  localparam logic [DATA_WIDTH-1:0] WORD_MASK = ~DATA_WIDTH'(3);

  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] raw_target;
  logic [DATA_WIDTH-1:0] redirect_target;
  logic                  redirect;
  logic                  misaligned;
  logic                  load_bubble;
  pc_src_e               pc_src;

  assign PCAddress  = pc;
  assign pc_plus4   = pc + DATA_WIDTH'(4);
  assign redirect   = Jump | BranchTaken;
  assign raw_target = Jump ? JumpTarget : BranchTarget;

  // Without the alignment check the low bits are simply dropped, keeping PC word aligned.
  assign redirect_target = raw_target & WORD_MASK;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = redirect && (raw_target[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // NOTE: every output of a combinational block is given a default first so no latch is inferred.
  always_comb begin
    pc_src      = SRC_SEQ;
    load_bubble = Flush;
    if (redirect) begin
      pc_src      = misaligned ? SRC_TRAP : SRC_REDIRECT;
      load_bubble = 1'b1;
    end else if (Stall) begin
      pc_src = SRC_HOLD;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_VECTOR & WORD_MASK;
      InstructionID <= NOP_WORD;
      PCPlus4ID     <= '0;
      ValidID       <= 1'b0;
    end else begin
      case (pc_src)
        SRC_SEQ:      pc <= pc_plus4;
        SRC_HOLD:     pc <= pc;
        SRC_REDIRECT: pc <= redirect_target;
        SRC_TRAP:     pc <= TRAP_VECTOR & WORD_MASK;
        default:      pc <= pc;
      endcase

      // The word returned for the current PC is wrong-path on redirect, so it becomes a bubble.
      if (load_bubble) begin
        InstructionID <= NOP_WORD;
        PCPlus4ID     <= '0;
        ValidID       <= 1'b0;
      end else if (pc_src == SRC_SEQ) begin
        InstructionID <= Instruction;
        PCPlus4ID     <= pc_plus4;
        ValidID       <= 1'b1;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) AlignError <= 1'b0;
    else       AlignError <= misaligned;
  end
`else
  assign AlignError = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus randomized traffic
// compared against a behavioural next-state model of the fetch stage.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] TV  = 32'h0000_0040;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0, flush = 1'b0, branch_taken = 1'b0, jump = 1'b0;
  logic [31:0] branch_target = '0, jump_target = '0;
  logic [31:0] pc_address, instruction, instruction_id, pc_plus4_id;
  logic        valid_id, align_error;

  int checks = 0;
  int failures = 0;

  // Model of the IF/ID-visible state
  logic [31:0] m_pc = RV, m_ins = NOP, m_p4 = 0;
  logic        m_v = 0, m_al = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF ^ {a[31:16], 16'h0};
  endfunction

  assign instruction = rom_word(pc_address);

  instruction_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .Stall        (stall),
    .Flush        (flush),
    .BranchTaken  (branch_taken),
    .BranchTarget (branch_target),
    .Jump         (jump),
    .JumpTarget   (jump_target),
    .PCAddress    (pc_address),
    .Instruction  (instruction),
    .InstructionID(instruction_id),
    .PCPlus4ID    (pc_plus4_id),
    .ValidID      (valid_id),
    .AlignError   (align_error)
  );

  // Drive one cycle of inputs, advance the model by the fetch rules, then sample after the edge.
  task automatic step(input logic rst, input logic st, input logic fl, input logic br,
                      input logic [31:0] bt, input logic j, input logic [31:0] jt);
    logic [31:0] t;
    reset = rst; stall = st; flush = fl;
    branch_taken = br; branch_target = bt; jump = j; jump_target = jt;
    if (rst) begin
      m_pc = RV; m_ins = NOP; m_p4 = 0; m_v = 0; m_al = 0;
    end else begin
      m_al = 0;
      if (j || br) begin
        t = j ? jt : bt;
`ifdef FETCH_ALIGN_CHECK_EN
        if (t % 4 != 0) begin m_pc = TV; m_al = 1; end
        else m_pc = t;
`else
        m_pc = t - (t % 4);
`endif
        m_ins = NOP; m_p4 = 0; m_v = 0;
      end else if (st) begin
        if (fl) begin m_ins = NOP; m_p4 = 0; m_v = 0; end
      end else begin
        if (fl) begin m_ins = NOP; m_p4 = 0; m_v = 0; end
        else begin m_ins = rom_word(m_pc); m_p4 = m_pc + 32'd4; m_v = 1; end
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic free_step();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    checks += 5;
    if (pc_address !== RV) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc_address, RV); end
    if (instruction_id !== NOP) begin failures++; $display("FAIL reset_ins got=%h exp=%h", instruction_id, NOP); end
    if (pc_plus4_id !== 32'h0) begin failures++; $display("FAIL reset_p4 got=%h exp=0", pc_plus4_id); end
    if (valid_id !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_id); end
    if (align_error !== 1'b0) begin failures++; $display("FAIL reset_align got=%b exp=0", align_error); end
  endtask

  task automatic test_sequential();
    step(1, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      free_step();
      checks += 4;
      if (pc_address !== 32'(4 * k)) begin failures++; $display("FAIL seq_pc[%0d] got=%h exp=%h", k, pc_address, 32'(4 * k)); end
      if (instruction_id !== rom_word(32'(4 * (k - 1)))) begin
        failures++; $display("FAIL seq_ins[%0d] got=%h exp=%h", k, instruction_id, rom_word(32'(4 * (k - 1))));
      end
      if (pc_plus4_id !== 32'(4 * k)) begin failures++; $display("FAIL seq_p4[%0d] got=%h exp=%h", k, pc_plus4_id, 32'(4 * k)); end
      if (valid_id !== 1'b1) begin failures++; $display("FAIL seq_valid[%0d] got=%b exp=1", k, valid_id); end
    end
  endtask

  task automatic test_stall();
    step(1, 0, 0, 0, 0, 0, 0);
    free_step();
    free_step();
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 0, 0, 0, 0);
      checks += 4;
      if (pc_address !== 32'h8) begin failures++; $display("FAIL stall_pc[%0d] got=%h exp=8", k, pc_address); end
      if (instruction_id !== rom_word(32'h4)) begin failures++; $display("FAIL stall_ins[%0d] got=%h exp=%h", k, instruction_id, rom_word(32'h4)); end
      if (pc_plus4_id !== 32'h8) begin failures++; $display("FAIL stall_p4[%0d] got=%h exp=8", k, pc_plus4_id); end
      if (valid_id !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d] got=%b exp=1", k, valid_id); end
    end
    free_step();
    checks += 2;
    if (pc_address !== 32'hC) begin failures++; $display("FAIL stall_release_pc got=%h exp=c", pc_address); end
    if (instruction_id !== rom_word(32'h8)) begin failures++; $display("FAIL stall_release_ins got=%h exp=%h", instruction_id, rom_word(32'h8)); end
  endtask

  task automatic test_branch_over_stall();
    step(0, 1, 0, 1, 32'h20, 0, 0);
    checks += 4;
    if (pc_address !== 32'h20) begin failures++; $display("FAIL br_stall_pc got=%h exp=20", pc_address); end
    if (valid_id !== 1'b0) begin failures++; $display("FAIL br_stall_valid got=%b exp=0", valid_id); end
    if (instruction_id !== NOP) begin failures++; $display("FAIL br_stall_ins got=%h exp=%h", instruction_id, NOP); end
    if (pc_plus4_id !== 32'h0) begin failures++; $display("FAIL br_stall_p4 got=%h exp=0", pc_plus4_id); end
  endtask

  task automatic test_jump_priority();
    step(0, 0, 0, 1, 32'h20, 1, 32'h40);
    checks += 1;
    if (pc_address !== 32'h40) begin failures++; $display("FAIL jump_prio_pc got=%h exp=40", pc_address); end
    step(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    checks += 1;
    if (pc_address !== 32'hFFFF_FFFC) begin failures++; $display("FAIL jump_top_pc got=%h exp=fffffffc", pc_address); end
    free_step();
    checks += 4;
    if (pc_address !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=0", pc_address); end
    if (pc_plus4_id !== 32'h0) begin failures++; $display("FAIL wrap_p4 got=%h exp=0", pc_plus4_id); end
    if (instruction_id !== rom_word(32'hFFFF_FFFC)) begin failures++; $display("FAIL wrap_ins got=%h exp=%h", instruction_id, rom_word(32'hFFFF_FFFC)); end
    if (valid_id !== 1'b1) begin failures++; $display("FAIL wrap_valid got=%b exp=1", valid_id); end
  endtask

  task automatic test_misaligned();
    logic [31:0] exp_pc;
    logic        exp_al;
`ifdef FETCH_ALIGN_CHECK_EN
    exp_pc = 32'h40; exp_al = 1'b1;
`else
    exp_pc = 32'h20; exp_al = 1'b0;
`endif
    step(0, 0, 0, 0, 0, 1, 32'h22);
    checks += 3;
    if (pc_address !== exp_pc) begin failures++; $display("FAIL misalign_pc got=%h exp=%h", pc_address, exp_pc); end
    if (align_error !== exp_al) begin failures++; $display("FAIL misalign_err got=%b exp=%b", align_error, exp_al); end
    if (valid_id !== 1'b0) begin failures++; $display("FAIL misalign_valid got=%b exp=0", valid_id); end
    free_step();
    checks += 2;
    if (align_error !== 1'b0) begin failures++; $display("FAIL misalign_pulse got=%b exp=0", align_error); end
    if (pc_address !== exp_pc + 32'd4) begin failures++; $display("FAIL misalign_next_pc got=%h exp=%h", pc_address, exp_pc + 32'd4); end
  endtask

  task automatic test_flush();
    logic [31:0] p;
    p = m_pc;
    free_step();
    step(0, 1, 1, 0, 0, 0, 0);
    checks += 3;
    if (pc_address !== p + 32'd4) begin failures++; $display("FAIL flush_stall_pc got=%h exp=%h", pc_address, p + 32'd4); end
    if (valid_id !== 1'b0) begin failures++; $display("FAIL flush_stall_valid got=%b exp=0", valid_id); end
    if (instruction_id !== NOP) begin failures++; $display("FAIL flush_stall_ins got=%h exp=%h", instruction_id, NOP); end
    step(0, 0, 1, 0, 0, 0, 0);
    checks += 3;
    if (pc_address !== p + 32'd8) begin failures++; $display("FAIL flush_pc got=%h exp=%h", pc_address, p + 32'd8); end
    if (valid_id !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", valid_id); end
    if (pc_plus4_id !== 32'h0) begin failures++; $display("FAIL flush_p4 got=%h exp=0", pc_plus4_id); end
  endtask

  task automatic test_reset_mid_stall();
    step(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) free_step();
    checks += 1;
    if (pc_address !== 32'h14) begin failures++; $display("FAIL pre_reset_pc got=%h exp=14", pc_address); end
    step(1, 1, 0, 0, 0, 0, 0);
    checks += 3;
    if (pc_address !== RV) begin failures++; $display("FAIL rst_stall_pc got=%h exp=%h", pc_address, RV); end
    if (valid_id !== 1'b0) begin failures++; $display("FAIL rst_stall_valid got=%b exp=0", valid_id); end
    if (instruction_id !== NOP) begin failures++; $display("FAIL rst_stall_ins got=%h exp=%h", instruction_id, NOP); end
    free_step();
    step(1, 0, 0, 1, 32'h80, 1, 32'h100);
    checks += 1;
    if (pc_address !== RV) begin failures++; $display("FAIL rst_redirect_pc got=%h exp=%h", pc_address, RV); end
  endtask

  task automatic test_random();
    logic        r, st, fl, br, j;
    logic [31:0] bt, jt;
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 49) == 0);
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 5) == 0);
      br = ($urandom_range(0, 9) == 0);
      j  = ($urandom_range(0, 14) == 0);
      bt = $urandom();
      jt = $urandom();
      if ($urandom_range(0, 1) == 0) bt[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 0) jt[1:0] = 2'b00;
      step(r, st, fl, br, bt, j, jt);
      checks += 6;
      if (pc_address !== m_pc) begin failures++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", n, pc_address, m_pc); end
      if (pc_address[1:0] !== 2'b00) begin failures++; $display("FAIL rnd_align[%0d] got=%b exp=00", n, pc_address[1:0]); end
      if (instruction_id !== m_ins) begin failures++; $display("FAIL rnd_ins[%0d] got=%h exp=%h", n, instruction_id, m_ins); end
      if (pc_plus4_id !== m_p4) begin failures++; $display("FAIL rnd_p4[%0d] got=%h exp=%h", n, pc_plus4_id, m_p4); end
      if (valid_id !== m_v) begin failures++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", n, valid_id, m_v); end
      if (align_error !== m_al) begin failures++; $display("FAIL rnd_alignerr[%0d] got=%b exp=%b", n, align_error, m_al); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_over_stall();
    test_jump_priority();
    test_misaligned();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
